// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RV32I load/store width codes and the LSU state encoding.
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RDW  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_e;

  // Unsigned widths only exist for loads; 011/110/111 are never legal.
  function automatic logic f3_legal(input logic [2:0] f3, input logic wr);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~wr;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Request/response and RAM-side signal bundle of the load/store unit.
interface lsu_mem_port_if #(
  parameter int AW = 15
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_write_en;
  logic          mem_read_en;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_write_en, mem_read_en, mem_address, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_write_en, mem_read_en, mem_address, mem_wdata
  );
endinterface

// File: rtl/lsu_lane.sv
// Combinational lane logic: load extract/extend and store byte-merge into a read word.
module lsu_lane
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane and extend it to 32 bits.
  always_comb begin
    byte_s    = 8'd0;
    half_s    = offset[1] ? rdata[31:16] : rdata[15:0];
    load_data = 32'd0;
    case (offset)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'd0;
    endcase
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_data = {24'd0, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_HU:   load_data = {16'd0, half_s};
      F3_W:    load_data = rdata;
      default: load_data = 32'd0;
    endcase
  end

  // Replace only the addressed byte/halfword of the old word.
  always_comb begin
    merge_data = rdata;
    case (funct3)
      F3_B: begin
        case (offset)
          2'd0:    merge_data[7:0]   = wdata[7:0];
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          2'd3:    merge_data[31:24] = wdata[7:0];
          default: merge_data = rdata;
        endcase
      end
      F3_H: begin
        if (offset[1]) begin
          merge_data[31:16] = wdata[15:0];
        end else begin
          merge_data[15:0] = wdata[15:0];
        end
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit front end to a single-port word RAM with read-modify-write for SB/SH.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/HU/W instead of masking the low address bits.
module lsu_mem_port
  import cpu_pkg::*;
#(
  parameter int MEMSIZE = 32768
) (
  input logic           clock,
  input logic           reset_n,
  lsu_mem_port_if.slave bus
);

  localparam int AW = $clog2(MEMSIZE);

  lsu_state_e    state_r, next_s;
  logic [2:0]    funct3_r;
  logic          write_r;
  logic [31:0]   wdata_r;
  logic [1:0]    offset_r;
  logic [1:0]    offset_s;
  logic          legal_s;
  logic          misalign_s;
  logic          trap_en_s;
  logic [31:0]   load_s;
  logic [31:0]   merge_s;
  logic          req_ready_r;
  logic          rsp_valid_r;
  logic          rsp_err_r;
  logic [31:0]   rsp_rdata_r;
  logic          mem_read_en_r;
  logic          mem_write_en_r;
  logic [AW-1:0] mem_address_r;
  logic [31:0]   mem_wdata_r;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_en_s = 1'b1;
`else
  assign trap_en_s = 1'b0;
`endif

  // Aligned lane offset of the incoming request and its legality.
  always_comb begin
    offset_s   = bus.req_addr[1:0];
    misalign_s = 1'b0;
    case (bus.req_funct3)
      F3_H, F3_HU: begin
        offset_s[0] = 1'b0;
        misalign_s  = bus.req_addr[0];
      end
      F3_W: begin
        offset_s   = 2'b00;
        misalign_s = (bus.req_addr[1:0] != 2'b00);
      end
      default: begin
        offset_s   = bus.req_addr[1:0];
        misalign_s = 1'b0;
      end
    endcase
    legal_s = f3_legal(bus.req_funct3, bus.req_write) && !(trap_en_s && misalign_s);
  end

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (!legal_s) begin
            next_s = ST_RESP;
          end else if (bus.req_write && (bus.req_funct3 == F3_W)) begin
            next_s = ST_WR;
          end else begin
            next_s = ST_RD;
          end
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_RD:   next_s = ST_RDW;
      ST_RDW:  next_s = write_r ? ST_WR : ST_RESP;
      ST_WR:   next_s = ST_RESP;
      ST_RESP: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  lsu_lane u_lane (
    .funct3     (funct3_r),
    .offset     (offset_r),
    .rdata      (bus.mem_rdata),
    .wdata      (wdata_r),
    .load_data  (load_s),
    .merge_data (merge_s)
  );

  // State register, request latch and registered outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      funct3_r       <= 3'd0;
      write_r        <= 1'b0;
      wdata_r        <= 32'd0;
      offset_r       <= 2'd0;
      req_ready_r    <= 1'b1;
      rsp_valid_r    <= 1'b0;
      rsp_err_r      <= 1'b0;
      rsp_rdata_r    <= 32'd0;
      mem_read_en_r  <= 1'b0;
      mem_write_en_r <= 1'b0;
      mem_address_r  <= '0;
      mem_wdata_r    <= 32'd0;
    end else begin
      state_r <= next_s;
      if ((state_r == ST_IDLE) && bus.req_valid) begin
        funct3_r      <= bus.req_funct3;
        write_r       <= bus.req_write;
        wdata_r       <= bus.req_wdata;
        offset_r      <= offset_s;
        mem_address_r <= bus.req_addr[AW+1:2];
      end
      // SW takes store data straight from the request; SB/SH write the merged word.
      if (next_s == ST_WR) begin
        mem_wdata_r <= (state_r == ST_RDW) ? merge_s : bus.req_wdata;
      end
      req_ready_r    <= (next_s == ST_IDLE);
      mem_read_en_r  <= (next_s == ST_RD);
      mem_write_en_r <= (next_s == ST_WR);
      rsp_valid_r    <= (next_s == ST_RESP);
      rsp_err_r      <= (next_s == ST_RESP) && (state_r == ST_IDLE);
      rsp_rdata_r    <= ((state_r == ST_RDW) && (next_s == ST_RESP)) ? load_s : 32'd0;
    end
  end

  assign bus.req_ready    = req_ready_r;
  assign bus.rsp_valid    = rsp_valid_r;
  assign bus.rsp_err      = rsp_err_r;
  assign bus.rsp_rdata    = rsp_rdata_r;
  assign bus.mem_read_en  = mem_read_en_r;
  assign bus.mem_write_en = mem_write_en_r;
  assign bus.mem_address  = mem_address_r;
  assign bus.mem_wdata    = mem_wdata_r;

endmodule
